// File: rtl/cola_fifo_param.sv
// Parametrised first-word-fall-through FIFO with occupancy count, level flags, flush and a two-word lookahead.
// Latency: a pushed word is visible on data the cycle after the push edge; pops take effect at the edge.
// Backpressure: push when full is accepted only with a simultaneous pop; rejected requests raise error and sticky flags.
module cola_fifo_param #(
    parameter int B        = 8,
    parameter int W        = 4,
    parameter int AF_LEVEL = (1 << W) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] in,
    output logic [B-1:0] data,
    output logic [B-1:0] data2,
    output logic         data2_valid,
    output logic [W:0]   count,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic         error,
    output logic         overflow,
    output logic         underflow
);

    localparam int         DEPTH_I = 1 << W;
    localparam logic [W:0] DEPTH   = (W+1)'(DEPTH_I);
    localparam logic [W:0] AF_LVL  = (W+1)'(AF_LEVEL);
    localparam logic [W:0] AE_LVL  = (W+1)'(AE_LEVEL);
    localparam logic [W:0] CNT_TWO = (W+1)'(2);
    localparam logic [W:0] CNT_INC = (W+1)'(1);
    localparam logic [W-1:0] PTR_INC = W'(1);

    logic [B-1:0] mem [DEPTH_I];

    logic [W-1:0] w_ptr_q, w_ptr_d;
    logic [W-1:0] r_ptr_q, r_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         wr_en, rd_en;
    logic         mem_we;

    // Every flag below is a function of registered count only, so wr/rd never reach them combinationally.
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign data2_valid  = (count_q >= CNT_TWO);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Fall-through read of the head and the word behind it; pointer arithmetic wraps mod depth.
    assign data  = mem[r_ptr_q];
    assign data2 = mem[r_ptr_q + PTR_INC];

    // Accept/reject decisions and next-state for pointers, occupancy and sticky flags.
    always_comb begin
        rd_en       = rd & ~empty;
        // A full FIFO can still take a push if the head leaves in the same cycle.
        wr_en       = wr & (~full | rd);
        error       = 1'b0;
        mem_we      = 1'b0;
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            // Flush wins over any request in the same cycle and reports no error.
            w_ptr_d     = '0;
            r_ptr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            error       = (wr & ~wr_en) | (rd & ~rd_en);
            overflow_d  = overflow_q | (wr & ~wr_en);
            underflow_d = underflow_q | (rd & ~rd_en);
            mem_we      = wr_en;
            case ({wr_en, rd_en})
                2'b10: begin
                    w_ptr_d = w_ptr_q + PTR_INC;
                    count_d = count_q + CNT_INC;
                end
                2'b01: begin
                    r_ptr_d = r_ptr_q + PTR_INC;
                    count_d = count_q - CNT_INC;
                end
                2'b11: begin
                    w_ptr_d = w_ptr_q + PTR_INC;
                    r_ptr_d = r_ptr_q + PTR_INC;
                end
                default: ;
            endcase
        end
    end

    // Control state register; cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are deliberately left unreset since pointers define validity.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[w_ptr_q] <= in;
        end
    end

endmodule

// File: tb/tb_cola_fifo_param.sv
module tb_cola_fifo_param;

    localparam int B     = 8;
    localparam int W     = 4;
    localparam int DEPTH = 1 << W;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic         wr;
    logic         rd;
    logic [B-1:0] din;
    logic [B-1:0] data;
    logic [B-1:0] data2;
    logic         data2_valid;
    logic [W:0]   count;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic         error;
    logic         overflow;
    logic         underflow;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: a queue of words plus the two sticky bits.
    logic [B-1:0] mq[$];
    bit           m_ov;
    bit           m_un;

    cola_fifo_param #(.B(B), .W(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .wr           (wr),
        .rd           (rd),
        .in           (din),
        .data         (data),
        .data2        (data2),
        .data2_valid  (data2_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = mq.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("data2_valid", 32'(data2_valid), 32'(n >= 2));
        check("overflow", 32'(overflow), 32'(m_ov));
        check("underflow", 32'(underflow), 32'(m_un));
        if (n >= 1) check("data", 32'(data), 32'(mq[0]));
        if (n >= 2) check("data2", 32'(data2), 32'(mq[1]));
    endtask

    // Called just after a falling edge: drive, check error, take the rising edge, update model, check.
    task automatic step(input bit w, input bit r, input logic [B-1:0] d, input bit f);
        bit rd_ok, wr_ok, exp_err;
        wr    = w;
        rd    = r;
        din   = d;
        flush = f;
        rd_ok   = r && (mq.size() > 0);
        wr_ok   = w && ((mq.size() < DEPTH) || r);
        exp_err = !f && ((w && !wr_ok) || (r && !rd_ok));
        #1;
        check("error", 32'(error), 32'(exp_err));
        @(posedge clk);
        #1;
        if (f) begin
            mq.delete();
            m_ov = 0;
            m_un = 0;
        end else begin
            if (rd_ok) void'(mq.pop_front());
            if (wr_ok) mq.push_back(d);
            if (w && !wr_ok) m_ov = 1;
            if (r && !rd_ok) m_un = 1;
        end
        check_state();
        @(negedge clk);
        wr    = 1'b0;
        rd    = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        din     = '0;
        m_ov    = 0;
        m_un    = 0;
        #12;
        // Reset values as absolute constants.
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_ov", 32'(overflow), 32'd0);
        check("rst_un", 32'(underflow), 32'd0);
        check("rst_d2v", 32'(data2_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Fill to full with 0x00..0x0F.
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 8'(i), 0);
            if (i == AF - 2) check("af_before", 32'(almost_full), 32'd0);
            if (i == AF - 1) check("af_at_14", 32'(almost_full), 32'd1);
        end
        check("fill_count", 32'(count), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_data", 32'(data), 32'h00);
        check("fill_data2", 32'(data2), 32'h01);

        // Push while full without pop: rejected, sticky overflow.
        step(1, 0, 8'hAA, 0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        step(0, 0, 8'h00, 0);
        check("ovf_hold", 32'(overflow), 32'd1);

        // Push with pop while full.
        step(1, 1, 8'h55, 0);
        check("wrrd_full_data", 32'(data), 32'h01);
        check("wrrd_full_count", 32'(count), 32'd16);

        // Drain; the model checks that 0x55 comes out last.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0);
        check("drain_empty", 32'(empty), 32'd1);

        // Push with pop while empty: only the push lands.
        step(1, 1, 8'h33, 0);
        check("empty_wrrd_un", 32'(underflow), 32'd1);
        check("empty_wrrd_data", 32'(data), 32'h33);

        // Flush, then wrap the pointers.
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom_range(0, 255)), 0);
        for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 8'($urandom_range(0, 255)), 0);
        for (int i = 0; i < 12; i++) step(0, 1, 8'h00, 0);

        // Flush at count 7 while requests are also asserted.
        step(0, 1, 8'h00, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h80 + i), 0);
        step(1, 1, 8'hEE, 1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_un", 32'(underflow), 32'd0);

        // Reset asserted mid-push.
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h90 + i), 0);
        wr  = 1'b1;
        din = 8'h77;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        mq.delete();
        m_ov = 0;
        m_un = 0;
        @(posedge clk);
        #1;
        check("arst_hold", 32'(count), 32'd0);
        @(negedge clk);
        wr      = 1'b0;
        reset_n = 1'b1;
        step(1, 0, 8'h42, 0);
        check("post_rst_push", 32'(data), 32'h42);

        // Randomised traffic alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 800; i++) begin
            bit fill_phase;
            fill_phase = ((i / 100) % 2) == 0;
            step($urandom_range(0, 99) < (fill_phase ? 75 : 30),
                 $urandom_range(0, 99) < (fill_phase ? 30 : 75),
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
